// File: rtl/div_operand_sequencer.sv
`default_nettype none
// ============================================================================
// div_operand_sequencer : FIFO-buffered load/start sequencer for a divider
// Revision: 1.0
// ============================================================================
module div_operand_sequencer #(
  parameter int W     = 10,
  parameter int DEPTH = 4,
  parameter int TMO   = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W-1:0]             in_a,
  input  logic [W-1:0]             in_b,
  output logic [W-1:0]             div_A,
  output logic [W-1:0]             div_B,
  output logic                     div_ld_a,
  output logic                     div_ld_b,
  output logic                     div_loading_done,
  output logic                     div_start,
  input  logic [W-1:0]             div_Q,
  input  logic                     div_ov,
  input  logic                     div_dvz,
  input  logic                     div_done,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [W-1:0]             res_q,
  output logic                     res_ov,
  output logic                     res_dvz,
  output logic                     res_tmo,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     busy
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = $clog2(TMO + 1);
  localparam logic [c_AW:0]   c_FULL     = (c_AW + 1)'(DEPTH);
  localparam logic [c_CW-1:0] c_TMO_LAST = c_CW'(TMO - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_START = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [2*W-1:0]      r_mem [DEPTH];
  logic [c_AW-1:0]     r_wr_ptr;
  logic [c_AW-1:0]     r_rd_ptr;
  logic [c_AW:0]       r_count;
  logic [c_CW-1:0]     r_tmo_cnt;
  logic [W-1:0]        r_div_a;
  logic [W-1:0]        r_div_b;
  logic                r_ld;
  logic                r_start;
  logic                r_lddone;
  logic                r_res_valid;
  logic [W-1:0]        r_res_q;
  logic                r_res_ov;
  logic                r_res_dvz;
  logic                r_res_tmo;
  logic                w_push;
  logic                w_pop;
  logic                w_slot_free;
  logic                w_cap_done;
  logic                w_cap_tmo;
  logic [2*W-1:0]      w_head;

  // Admission uses only the registered count, so a pop never frees a slot early.
  assign in_ready    = (r_count < c_FULL);
  assign w_push      = in_valid & in_ready;
  assign w_pop       = (r_state == S_START);
  assign w_slot_free = !r_res_valid | res_ready;
  assign w_head      = r_mem[r_rd_ptr];

  always_comb begin
    w_next     = r_state;
    w_cap_done = 1'b0;
    w_cap_tmo  = 1'b0;
    case (r_state)
      S_IDLE:  if ((r_count != '0) && w_slot_free) w_next = S_LOAD;
      S_LOAD:  w_next = S_START;
      S_START: w_next = S_WAIT;
      S_WAIT: begin
        if (div_done) begin
          w_cap_done = 1'b1;
          w_next     = S_IDLE;
        end else if (r_tmo_cnt == c_TMO_LAST) begin
          w_cap_tmo = 1'b1;
          w_next    = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {in_a, in_b};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Divider controls are registered from the next state so they are glitch-free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_tmo_cnt <= '0;
      r_div_a   <= '0;
      r_div_b   <= '0;
      r_ld      <= 1'b0;
      r_start   <= 1'b0;
      r_lddone  <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_tmo_cnt <= ((r_state == S_WAIT) && (w_next == S_WAIT)) ? r_tmo_cnt + 1'b1 : '0;
      r_ld      <= (w_next == S_LOAD);
      r_start   <= (w_next == S_START);
      r_lddone  <= (w_next == S_START) || (w_next == S_WAIT);
      if ((r_state == S_IDLE) && (w_next == S_LOAD)) begin
        r_div_a <= w_head[2*W-1:W];
        r_div_b <= w_head[W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_res_valid <= 1'b0;
      r_res_q     <= '0;
      r_res_ov    <= 1'b0;
      r_res_dvz   <= 1'b0;
      r_res_tmo   <= 1'b0;
    end else if (w_cap_done) begin
      r_res_valid <= 1'b1;
      r_res_q     <= div_Q;
      r_res_ov    <= div_ov;
      r_res_dvz   <= div_dvz;
      r_res_tmo   <= 1'b0;
    end else if (w_cap_tmo) begin
      r_res_valid <= 1'b1;
      r_res_q     <= '0;
      r_res_ov    <= 1'b0;
      r_res_dvz   <= 1'b0;
      r_res_tmo   <= 1'b1;
    end else if (r_res_valid && res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

  assign div_A            = r_div_a;
  assign div_B            = r_div_b;
  assign div_ld_a         = r_ld;
  assign div_ld_b         = r_ld;
  assign div_start        = r_start;
  assign div_loading_done = r_lddone;
  assign res_valid        = r_res_valid;
  assign res_q            = r_res_q;
  assign res_ov           = r_res_ov;
  assign res_dvz          = r_res_dvz;
  assign res_tmo          = r_res_tmo;
  assign fifo_count       = r_count;
  assign busy             = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_div_operand_sequencer.sv
`default_nettype none
// ============================================================================
// tb_div_operand_sequencer : directed bench with a behavioural divider model
// Revision: 1.0
// ============================================================================
module tb_div_operand_sequencer;

  localparam int W     = 10;
  localparam int DEPTH = 4;
  localparam int TMO   = 64;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           in_valid, in_ready;
  logic [W-1:0]   in_a, in_b;
  logic [W-1:0]   div_A, div_B, div_Q;
  logic           div_ld_a, div_ld_b, div_loading_done, div_start;
  logic           div_ov, div_dvz, div_done;
  logic           res_valid, res_ready, res_ov, res_dvz, res_tmo;
  logic [W-1:0]   res_q;
  logic [$clog2(DEPTH):0] fifo_count;
  logic           busy;

  int n_pass  = 0;
  int n_total = 0;

  int           m_delay = 12;
  bit           m_hang  = 1'b0;
  int           m_cnt;
  logic [W-1:0] m_a, m_b;

  logic [W-1:0] sa [8] = '{10'd100, 10'd81, 10'd500, 10'd1023, 10'd7, 10'd999, 10'd64, 10'd250};
  logic [W-1:0] sb [8] = '{10'd10,  10'd9,  10'd7,   10'd1,    10'd2, 10'd3,   10'd8,  10'd25};
  logic [W-1:0] sq [8] = '{10'd10,  10'd9,  10'd71,  10'd1023, 10'd3, 10'd333, 10'd8,  10'd10};
  logic [W-1:0] rq [8];

  div_operand_sequencer #(.W(W), .DEPTH(DEPTH), .TMO(TMO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .div_A(div_A), .div_B(div_B), .div_ld_a(div_ld_a), .div_ld_b(div_ld_b),
    .div_loading_done(div_loading_done), .div_start(div_start),
    .div_Q(div_Q), .div_ov(div_ov), .div_dvz(div_dvz), .div_done(div_done),
    .res_valid(res_valid), .res_ready(res_ready), .res_q(res_q),
    .res_ov(res_ov), .res_dvz(res_dvz), .res_tmo(res_tmo),
    .fifo_count(fifo_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // Divider model: latches operands on start, pulses done m_delay cycles later.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cnt <= 0; div_done <= 1'b0; div_Q <= '0; div_ov <= 1'b0; div_dvz <= 1'b0;
    end else begin
      div_done <= 1'b0;
      if (div_start && !m_hang) begin
        m_cnt <= m_delay; m_a <= div_A; m_b <= div_B;
      end else if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          div_done <= 1'b1;
          div_ov   <= 1'b0;
          div_dvz  <= (m_b == '0);
          div_Q    <= (m_b == '0) ? '1 : m_a / m_b;
        end
      end
    end
  end

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
    bit ok = 1'b0;
    in_valid = 1'b1; in_a = a; in_b = b;
    for (int i = 0; i < 400 && !ok; i++) begin
      ok = in_ready;
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_total++;
    if (!ok) $display("FAIL push_accept: a=%0d b=%0d never accepted, want accepted", a, b);
    else n_pass++;
  endtask

  task automatic wait_res(output bit got);
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      got = res_valid;
    end
  endtask

  task automatic consume();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_total++; if ({in_ready, fifo_count, busy, res_valid} !== {1'b1, 3'd0, 1'b0, 1'b0})
      $display("FAIL reset_flags: rdy/cnt/busy/rv=%b want 1_000_0_0", {in_ready, fifo_count, busy, res_valid}); else n_pass++;
    n_total++; if ({div_A, div_B, div_ld_a, div_ld_b, div_loading_done, div_start} !== '0)
      $display("FAIL reset_div: div outputs=%h want 0", {div_A, div_B, div_ld_a, div_ld_b, div_loading_done, div_start}); else n_pass++;
    n_total++; if ({res_q, res_ov, res_dvz, res_tmo} !== '0)
      $display("FAIL reset_res: res=%h want 0", {res_q, res_ov, res_dvz, res_tmo}); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_total++; if ({in_ready, busy, res_valid, div_ld_a} !== 4'b1000)
      $display("FAIL reset_release: rdy/busy/rv/ld=%b want 1000", {in_ready, busy, res_valid, div_ld_a}); else n_pass++;
  endtask

  task automatic test_single();
    bit got;
    m_delay = 12;
    push(10'b0001101110, 10'd3);
    n_total++; if ({div_ld_a, fifo_count} !== {1'b0, 3'd1})
      $display("FAIL single_idle: ld/cnt=%b want 0_001", {div_ld_a, fifo_count}); else n_pass++;
    @(negedge clk);
    n_total++; if ({div_ld_a, div_ld_b, div_loading_done, div_start} !== 4'b1100)
      $display("FAIL single_load: ld_a/ld_b/lddone/start=%b want 1100", {div_ld_a, div_ld_b, div_loading_done, div_start}); else n_pass++;
    n_total++; if ({div_A, div_B} !== {10'd110, 10'd3})
      $display("FAIL single_operands: A=%0d B=%0d want 110 3", div_A, div_B); else n_pass++;
    @(negedge clk);
    n_total++; if ({div_ld_a, div_ld_b, div_loading_done, div_start} !== 4'b0011)
      $display("FAIL single_start: ld_a/ld_b/lddone/start=%b want 0011", {div_ld_a, div_ld_b, div_loading_done, div_start}); else n_pass++;
    @(negedge clk);
    n_total++; if ({div_start, div_loading_done, busy, fifo_count} !== {3'b011, 3'd0})
      $display("FAIL single_wait: start/lddone/busy/cnt=%b want 011_000", {div_start, div_loading_done, busy, fifo_count}); else n_pass++;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = div_done;
    end
    n_total++; if (!got || res_valid !== 1'b0)
      $display("FAIL single_done_latency: done=%b res_valid=%b want 1 0", got, res_valid); else n_pass++;
    @(negedge clk);
    n_total++; if ({res_valid, res_q, res_ov, res_dvz, res_tmo} !== {1'b1, 10'd36, 3'b000})
      $display("FAIL single_result: v=%b q=%0d ov/dvz/tmo=%b want 1 36 000", res_valid, res_q, {res_ov, res_dvz, res_tmo}); else n_pass++;
    n_total++; if ({busy, div_loading_done} !== 2'b00)
      $display("FAIL single_idle_after: busy/lddone=%b want 00", {busy, div_loading_done}); else n_pass++;
    consume();
  endtask

  task automatic test_fill();
    bit got;
    int n_ld;
    logic [W-1:0] last_q;
    m_delay = 5;
    push(10'd20, 10'd2); push(10'd33, 10'd3); push(10'd48, 10'd4);
    push(10'd65, 10'd5); push(10'd84, 10'd6);
    n_total++; if ({fifo_count, in_ready} !== {3'd4, 1'b0})
      $display("FAIL fill_full: cnt=%0d rdy=%b want 4 0", fifo_count, in_ready); else n_pass++;
    wait_res(got);
    n_total++; if (!got || res_q !== 10'd10)
      $display("FAIL fill_first: got=%b q=%0d want 1 10", got, res_q); else n_pass++;
    n_ld = 0;
    repeat (6) begin
      @(negedge clk);
      if (div_ld_a) n_ld++;
    end
    n_total++; if ({n_ld == 0, busy, fifo_count, res_valid} !== {1'b1, 1'b0, 3'd4, 1'b1})
      $display("FAIL fill_stalled: ld_pulses=%0d busy=%b cnt=%0d rv=%b want 0 0 4 1", n_ld, busy, fifo_count, res_valid); else n_pass++;
    consume();
    n_total++; if ({div_ld_a, div_A, res_valid} !== {1'b1, 10'd33, 1'b0})
      $display("FAIL fill_second_load: ld=%b A=%0d rv=%b want 1 33 0", div_ld_a, div_A, res_valid); else n_pass++;
    repeat (2) @(negedge clk);
    n_total++; if ({fifo_count, in_ready} !== {3'd3, 1'b1})
      $display("FAIL fill_pop: cnt=%0d rdy=%b want 3 1", fifo_count, in_ready); else n_pass++;
    res_ready = 1'b1;
    last_q = '0; got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (res_valid) last_q = res_q;
      got = (fifo_count == 0) && !busy && !res_valid && (last_q == 10'd14);
    end
    res_ready = 1'b0;
    n_total++; if (!got || last_q !== 10'd14)
      $display("FAIL fill_drain: drained=%b last_q=%0d want 1 14", got, last_q); else n_pass++;
  endtask

  task automatic test_dvz();
    bit got;
    m_delay = 4;
    push(10'd5, 10'd0);
    wait_res(got);
    n_total++; if (!got || {res_dvz, res_ov, res_tmo} !== 3'b100)
      $display("FAIL dvz_result: got=%b dvz/ov/tmo=%b want 1 100", got, {res_dvz, res_ov, res_tmo}); else n_pass++;
    n_total++; if (busy !== 1'b0)
      $display("FAIL dvz_idle: busy=%b want 0", busy); else n_pass++;
    consume();
  endtask

  task automatic test_timeout();
    bit got;
    int n_wait;
    m_hang = 1'b1; m_delay = 6;
    push(10'd9, 10'd3);
    push(10'd200, 10'd4);
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      if (div_start) got = 1'b1;
      else @(negedge clk);
    end
    n_wait = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (div_loading_done) n_wait++;
      else break;
    end
    n_total++; if (!got || n_wait != TMO)
      $display("FAIL tmo_wait_cycles: started=%b wait=%0d want 1 %0d", got, n_wait, TMO); else n_pass++;
    n_total++; if ({res_valid, res_tmo, res_q, res_ov, res_dvz} !== {2'b11, 10'd0, 2'b00})
      $display("FAIL tmo_result: v=%b tmo=%b q=%0d ov/dvz=%b want 1 1 0 00", res_valid, res_tmo, res_q, {res_ov, res_dvz}); else n_pass++;
    n_total++; if (fifo_count !== 3'd1)
      $display("FAIL tmo_queued: cnt=%0d want 1", fifo_count); else n_pass++;
    m_hang = 1'b0;
    consume();
    wait_res(got);
    n_total++; if (!got || {res_q, res_tmo} !== {10'd50, 1'b0})
      $display("FAIL tmo_next: got=%b q=%0d tmo=%b want 1 50 0", got, res_q, res_tmo); else n_pass++;
    consume();
  endtask

  task automatic test_reset_mid_wait();
    int n_seen;
    m_hang = 1'b1;
    push(10'd10, 10'd1); push(10'd20, 10'd2); push(10'd30, 10'd3);
    repeat (5) @(negedge clk);
    n_total++; if ({busy, div_loading_done, fifo_count} !== {2'b11, 3'd2})
      $display("FAIL rstw_pre: busy/lddone=%b cnt=%0d want 11 2", {busy, div_loading_done}, fifo_count); else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_total++; if ({fifo_count, in_ready, busy} !== {3'd0, 2'b10})
      $display("FAIL rstw_fifo: cnt=%0d rdy=%b busy=%b want 0 1 0", fifo_count, in_ready, busy); else n_pass++;
    n_total++; if ({div_A, div_B, div_ld_a, div_ld_b, div_loading_done, div_start} !== '0)
      $display("FAIL rstw_div: div outputs=%h want 0", {div_A, div_B, div_ld_a, div_ld_b, div_loading_done, div_start}); else n_pass++;
    n_total++; if ({res_valid, res_q, res_ov, res_dvz, res_tmo} !== '0)
      $display("FAIL rstw_res: res=%h want 0", {res_valid, res_q, res_ov, res_dvz, res_tmo}); else n_pass++;
    @(negedge clk);
    rst = 1'b1; m_hang = 1'b0; res_ready = 1'b1;
    n_seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (res_valid || busy) n_seen++;
    end
    res_ready = 1'b0;
    n_total++; if (n_seen != 0)
      $display("FAIL rstw_after: active cycles=%0d want 0", n_seen); else n_pass++;
  endtask

  task automatic test_streaming();
    int n_got, n_dup;
    m_delay = 3;
    res_ready = 1'b1;
    n_got = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) push(sa[i], sb[i]);
      end
      begin
        for (int c = 0; c < 600 && n_got < 8; c++) begin
          @(negedge clk);
          if (res_valid) begin
            rq[n_got] = res_q;
            n_got++;
          end
        end
      end
    join
    n_total++; if (n_got != 8)
      $display("FAIL stream_count: results=%0d want 8", n_got); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_total++; if (i >= n_got || rq[i] !== sq[i])
        $display("FAIL stream_q%0d: got %0d want %0d", i, rq[i], sq[i]); else n_pass++;
    end
    n_dup = 0;
    repeat (20) begin
      @(negedge clk);
      if (res_valid) n_dup++;
    end
    n_total++; if (n_dup != 0 || fifo_count !== 3'd0)
      $display("FAIL stream_tail: extra=%0d cnt=%0d want 0 0", n_dup, fifo_count); else n_pass++;
    res_ready = 1'b0;
  endtask

  initial begin
    in_valid = 1'b0; in_a = '0; in_b = '0; res_ready = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_dvz();
    test_timeout();
    test_streaming();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
